// File: rtl/instfetch_if.sv
// rtl/instfetch_if.sv - fetch-stage bus bundle: ROM port, redirect, decode handshake and fault flag.
interface instfetch_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        fault;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fault
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fault
  );
endinterface

// File: rtl/instfetch.sv
// rtl/instfetch.sv - PC register, 2-entry {instr, pc} buffer and RUN/FAULT mode FSM.
// Bounds/alignment fault detection is enabled by defining INSTFETCH_BOUNDS_CHECK_EN.
module instfetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  instfetch_if.master bus
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } mode_e;

`ifdef INSTFETCH_BOUNDS_CHECK_EN
  localparam bit FAULT_REPORT = 1'b1;
`else
  localparam bit FAULT_REPORT = 1'b0;
  localparam logic [15:0] ADDR_MASK = 16'(IMEM_SIZE - 1) & 16'hFFFC;
`endif

  // Without the checker every PC load folds into the ROM, so fetch wraps instead of faulting.
  function automatic logic [15:0] pc_load(input logic [15:0] v);
`ifdef INSTFETCH_BOUNDS_CHECK_EN
    pc_load = v;
`else
    pc_load = v & ADDR_MASK;
`endif
  endfunction

  mode_e       mode_q, mode_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q [2];
  logic [15:0] pcbuf_q [2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;

  logic run;
  logic pop;
  logic room;
  logic flush;
  logic want_fetch;
  logic range_bad;
  logic push;
  logic fault_hit;

  assign pop        = (count_q != 2'd0) && bus.out_ready;
  assign room       = (count_q != 2'd2) || pop;
  assign flush      = run && bus.redirect_valid;
  assign want_fetch = run && !bus.redirect_valid && room;
  assign push       = want_fetch && !range_bad;
  assign fault_hit  = want_fetch && range_bad;

`ifdef INSTFETCH_BOUNDS_CHECK_EN
  assign range_bad = (pc_q[1:0] != 2'b00) || (({1'b0, pc_q} + 17'd3) >= 17'(IMEM_SIZE));
`else
  assign range_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      RUN:     if (fault_hit) mode_d = FAULT;
      FAULT:   mode_d = FAULT;
      default: mode_d = RUN;
    endcase
  end

  always_comb begin
    run       = 1'b0;
    bus.fault = 1'b0;
    case (mode_q)
      RUN:     run = 1'b1;
      FAULT:   bus.fault = FAULT_REPORT;
      default: run = 1'b1;
    endcase
  end

  // Redirect flushes everything; a same-cycle pop is absorbed because the head goes too.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      pc_d    = pc_load(bus.redirect_target);
      head_d  = tail_q;
      count_d = 2'd0;
    end else begin
      if (push) begin
        pc_d   = pc_load(pc_q + 16'd4);
        tail_d = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= pc_load(RESET_PC);
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= 2'd0;
      instr_q[0] <= 16'h0000;
      instr_q[1] <= 16'h0000;
      pcbuf_q[0] <= 16'h0000;
      pcbuf_q[1] <= 16'h0000;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        instr_q[tail_q] <= bus.imem_instr;
        pcbuf_q[tail_q] <= pc_q;
      end
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_instr = instr_q[head_q];
  assign bus.out_pc    = pcbuf_q[head_q];

endmodule

// File: tb/tb_instfetch.sv
// tb/tb_instfetch.sv - scoreboard bench for instfetch; define INSTFETCH_BOUNDS_CHECK_EN to exercise the fault path.
`timescale 1ns/1ps
module tb_instfetch;
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam int unsigned IMEM_SIZE = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  instfetch_if bus();

  instfetch #(
    .RESET_PC (RESET_PC),
    .IMEM_SIZE(IMEM_SIZE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return 16'hA001 + {2'b00, a[15:2]};
  endfunction

  assign bus.imem_instr = rom(bus.imem_addr);

  logic [15:0] m_pc;
  logic [31:0] sb[$];
  bit          m_fault;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_load(input logic [15:0] v);
`ifdef INSTFETCH_BOUNDS_CHECK_EN
    return v;
`else
    return 16'((32'(v) % IMEM_SIZE) & ~32'd3);
`endif
  endfunction

  function automatic bit m_bad(input logic [15:0] v);
`ifdef INSTFETCH_BOUNDS_CHECK_EN
    return (v[1:0] != 2'b00) || ((int'(v) + 3) >= int'(IMEM_SIZE));
`else
    return (v[1:0] != 2'b00) && 1'b0;
`endif
  endfunction

  // Called at a falling edge: drive inputs, compare head against the scoreboard, advance the model.
  task automatic cycle(input bit rdy, input bit rv, input logic [15:0] tgt);
    bus.out_ready       = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    #1;
    chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    chk("fault", 32'(bus.fault), 32'(m_fault));
    if (sb.size() != 0) begin
      chk("out_instr", 32'(bus.out_instr), 32'(sb[0][31:16]));
      chk("out_pc", 32'(bus.out_pc), 32'(sb[0][15:0]));
      if (rdy) void'(sb.pop_front());
    end
    if (!m_fault && rv) begin
      sb.delete();
      m_pc = m_load(tgt);
    end else if (!m_fault && sb.size() < 2) begin
      if (m_bad(m_pc)) begin
        m_fault = 1'b1;
      end else begin
        sb.push_back({rom(m_pc), m_pc});
        m_pc = m_load(m_pc + 16'd4);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input bit rdy, input bit rv);
    reset               = 1'b1;
    bus.out_ready       = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = 16'h0040;
    @(negedge clk);
    reset   = 1'b0;
    sb.delete();
    m_pc    = m_load(RESET_PC);
    m_fault = 1'b0;
  endtask

  initial begin
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 16'h0000;
    @(negedge clk);

    // Reset release and streaming
    do_reset(1'b0, 1'b0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", 32'(bus.out_instr), 32'd0);
    chk("rst_out_pc", 32'(bus.out_pc), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'(RESET_PC));
    chk("rst_fault", 32'(bus.fault), 32'd0);
    cycle(1'b1, 1'b0, 16'h0);
    chk("first_instr", 32'(bus.out_instr), 32'hA001);
    repeat (6) cycle(1'b1, 1'b0, 16'h0);

    // Backpressure fill and release
    do_reset(1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 16'h0);
    chk("bp_stall_addr", 32'(bus.imem_addr), 32'h0008);
    chk("bp_head_pc", 32'(bus.out_pc), 32'h0000);
    repeat (6) cycle(1'b1, 1'b0, 16'h0);

    // Redirect with a full buffer and a same-cycle pop
    do_reset(1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h0040);
    chk("rd_bubble", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, 1'b0, 16'h0);
    chk("rd_head_pc", 32'(bus.out_pc), 32'h0040);
    repeat (3) cycle(1'b1, 1'b0, 16'h0);

`ifdef INSTFETCH_BOUNDS_CHECK_EN
    // Range fault at the top of the ROM
    cycle(1'b1, 1'b1, 16'h03FC);
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    chk("range_fault", 32'(bus.fault), 32'd1);
    repeat (2) cycle(1'b1, 1'b0, 16'h0);
    // Alignment fault, ignored redirect, drain, then reset recovery
    do_reset(1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0006);
    cycle(1'b1, 1'b0, 16'h0);
    chk("align_fault", 32'(bus.fault), 32'd1);
    cycle(1'b0, 1'b1, 16'h0000);
    chk("fault_redir_ignored", 32'(bus.imem_addr), 32'h0006);
    repeat (3) cycle(1'b1, 1'b0, 16'h0);
    do_reset(1'b1, 1'b0);
    chk("fault_cleared", 32'(bus.fault), 32'd0);
    chk("fault_restart_addr", 32'(bus.imem_addr), 32'(RESET_PC));
    repeat (3) cycle(1'b1, 1'b0, 16'h0);
`else
    // Wrap at the top of the ROM and target masking
    cycle(1'b1, 1'b1, 16'h03F8);
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    chk("wrap_addr", 32'(bus.imem_addr), 32'h0000);
    repeat (2) cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h0402);
    chk("mask_addr", 32'(bus.imem_addr), 32'h0000);
    chk("no_fault", 32'(bus.fault), 32'd0);
    repeat (3) cycle(1'b1, 1'b0, 16'h0);
`endif

    // Randomised traffic
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      logic [15:0] tgt;
`ifdef INSTFETCH_BOUNDS_CHECK_EN
      tgt = 16'($urandom_range(0, 255)) << 2;
`else
      tgt = 16'($urandom);
`endif
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, tgt);
    end

    // Reset mid-stream overrides a redirect and a pop
    do_reset(1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 16'h0);
    do_reset(1'b1, 1'b1);
    chk("mr_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_addr", 32'(bus.imem_addr), 32'(RESET_PC));
    chk("mr_fault", 32'(bus.fault), 32'd0);
    repeat (4) cycle(1'b1, 1'b0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
